// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared router defines (flit width, mux port count, flit type codes, arbiter states).
package mux_arb_pkg;
  localparam int DATAW = 66;
  localparam int PORT_P1 = 5;
  typedef enum logic [1:0] {FT_NONE = 2'b00, FT_HEAD = 2'b01, FT_DATA = 2'b10, FT_TAIL = 2'b11} flit_t;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  function automatic logic [1:0] flit_type(input logic [DATAW-1:0] f);
    return f[DATAW-1:DATAW-2];
  endfunction
endpackage

// File: rtl/mux_arb_rr_pick.sv
// rr_pick: two-requester round-robin pick; ptr breaks ties.
module rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  assign gnt_valid = |req;
  assign gnt_idx = &req ? ptr : req[1];
endmodule

// File: rtl/mux_arb.sv
// mux_arb: packet-level round-robin arbiter driving the 2:1 router output mux select and buffer pops.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int SELW = PORT_P1,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic            ordy,
  output logic [SELW-1:0] sel,
  output logic            ipop_0,
  output logic            ipop_1,
  output logic            busy,
  output logic [CNTW-1:0] flit_cnt,
  output logic            err
);
  state_t state, state_nxt;
  logic owner, ptr, gnt_valid, gnt_idx, own_valid, pop, tail_pop, bad_pop, idle_err;
  logic [1:0] own_type, req;
  assign own_valid = owner ? ivalid_1 : ivalid_0;
  assign own_type = owner ? itype_1 : itype_0;
  assign busy = state == LOCKED;
  assign pop = busy && own_valid && ordy;
  assign ipop_0 = pop && !owner;
  assign ipop_1 = pop && owner;
  assign tail_pop = pop && own_type == FT_TAIL;
  // a HEAD is only legal as the first popped flit of a packet
  assign bad_pop = pop && (own_type == FT_NONE || (own_type == FT_HEAD && flit_cnt != '0));
  assign idle_err = !busy && ((ivalid_0 && itype_0 != FT_HEAD) || (ivalid_1 && itype_1 != FT_HEAD));
  assign req = busy ? 2'b00 : {ivalid_1 && itype_1 == FT_HEAD, ivalid_0 && itype_0 == FT_HEAD};
  rr_pick u_pick (.req(req), .ptr(ptr), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx));
  always_comb begin
    state_nxt = busy ? (tail_pop ? IDLE : LOCKED) : (gnt_valid ? LOCKED : IDLE);
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      owner <= 1'b0;
      ptr <= 1'b0;
      sel <= '0;
      flit_cnt <= '0;
      err <= 1'b0;
    end else begin
      if (!busy && gnt_valid) begin
        owner <= gnt_idx;
        sel <= SELW'(1) << gnt_idx;
        flit_cnt <= '0;
      end
      if (pop) flit_cnt <= flit_cnt + CNTW'(~&flit_cnt);
      if (tail_pop) begin
        sel <= '0;
        ptr <= ~owner;
      end
      if (bad_pop || idle_err) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed self-checking bench for mux_arb.
module tb_mux_arb;
  import mux_arb_pkg::*;
  logic clk = 0, rst_ = 0, ivalid_0 = 0, ivalid_1 = 0, ordy = 0;
  logic [1:0] itype_0 = 0, itype_1 = 0;
  logic [4:0] sel;
  logic ipop_0, ipop_1, busy, err;
  logic [7:0] flit_cnt;
  int n_cmp = 0, n_err = 0;
  logic [1:0] pkt5 [5];

  mux_arb dut (
    .clk(clk), .rst_(rst_), .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1), .ordy(ordy), .sel(sel),
    .ipop_0(ipop_0), .ipop_1(ipop_1), .busy(busy), .flit_cnt(flit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [1:0] t0, input logic v1, input logic [1:0] t1, input logic r);
    ivalid_0 = v0; itype_0 = t0; ivalid_1 = v1; itype_1 = t1; ordy = r;
    #2;
  endtask

  task automatic do_reset;
    drv(0, FT_NONE, 0, FT_NONE, 0);
    rst_ = 0;
    tick;
    rst_ = 1;
  endtask

  initial begin
    pkt5 = '{FT_HEAD, FT_DATA, FT_DATA, FT_DATA, FT_TAIL};
    tick;
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", flit_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_pop0", ipop_0, 0);
    chk("rst_pop1", ipop_1, 0);
    rst_ = 1;
    // single 22-flit packet on input 1
    drv(0, FT_NONE, 1, FT_HEAD, 1);
    chk("a_idle_pop1", ipop_1, 0);
    tick;
    chk("a_sel", sel, 5'b00010);
    chk("a_busy", busy, 1);
    chk("a_cnt0", flit_cnt, 0);
    for (int k = 0; k < 22; k++) begin
      drv(0, FT_NONE, 1, k == 0 ? FT_HEAD : (k == 21 ? FT_TAIL : FT_DATA), 1);
      chk("a_pop1", ipop_1, 1);
      chk("a_pop0", ipop_0, 0);
      tick;
      chk("a_cnt", flit_cnt, k + 1);
      chk("a_sel_run", sel, k == 21 ? 0 : 5'b00010);
    end
    drv(0, FT_NONE, 0, FT_NONE, 1);
    chk("a_end_busy", busy, 0);
    chk("a_end_cnt", flit_cnt, 22);
    chk("a_err", err, 0);
    tick;
    // simultaneous HEADs, ptr=0 after reset
    do_reset;
    drv(1, FT_HEAD, 1, FT_HEAD, 1);
    chk("b_idle_pop0", ipop_0, 0);
    chk("b_idle_pop1", ipop_1, 0);
    tick;
    chk("b_sel0", sel, 5'b00001);
    drv(1, FT_HEAD, 1, FT_HEAD, 1);
    chk("b_head_pop0", ipop_0, 1);
    chk("b_head_pop1", ipop_1, 0);
    tick;
    chk("b_cnt1", flit_cnt, 1);
    drv(1, FT_TAIL, 1, FT_HEAD, 1);
    chk("b_tail_pop0", ipop_0, 1);
    tick;
    chk("b_sel_idle", sel, 0);
    chk("b_busy_idle", busy, 0);
    chk("b_cnt2", flit_cnt, 2);
    drv(0, FT_NONE, 1, FT_HEAD, 1);
    chk("b_bubble_pop1", ipop_1, 0);
    tick;
    chk("b_sel1", sel, 5'b00010);
    chk("b_cnt_regrant", flit_cnt, 0);
    // input 0 HEAD arrives during input 1's packet
    for (int k = 0; k < 4; k++) begin
      drv(1, FT_HEAD, 1, k == 0 ? FT_HEAD : (k == 3 ? FT_TAIL : FT_DATA), 1);
      chk("c_pop0", ipop_0, 0);
      chk("c_pop1", ipop_1, 1);
      chk("c_sel", sel, 5'b00010);
      tick;
    end
    chk("c_cnt", flit_cnt, 4);
    chk("c_sel_end", sel, 0);
    chk("c_err", err, 0);
    drv(0, FT_NONE, 0, FT_NONE, 1);
    tick;
    // ordy toggling during a 5-flit packet on input 0
    drv(1, FT_HEAD, 0, FT_NONE, 0);
    tick;
    chk("d_sel", sel, 5'b00001);
    begin
      int idx = 0;
      for (int c = 0; c < 9; c++) begin
        drv(1, pkt5[idx], 0, FT_NONE, (c % 2) == 0);
        chk("d_pop0", ipop_0, (c % 2) == 0);
        tick;
        if ((c % 2) == 0) idx++;
        chk("d_cnt", flit_cnt, idx);
      end
    end
    chk("d_busy_end", busy, 0);
    chk("d_sel_end", sel, 0);
    chk("d_err", err, 0);
    drv(0, FT_NONE, 0, FT_NONE, 1);
    tick;
    // reset mid-packet after 3 flits
    drv(1, FT_HEAD, 0, FT_NONE, 1);
    tick;
    chk("e_sel", sel, 5'b00001);
    for (int k = 0; k < 3; k++) begin
      drv(1, k == 0 ? FT_HEAD : FT_DATA, 0, FT_NONE, 1);
      tick;
    end
    chk("e_cnt3", flit_cnt, 3);
    drv(1, FT_DATA, 0, FT_NONE, 1);
    chk("e_pre_pop0", ipop_0, 1);
    rst_ = 0;
    #1;
    chk("e_rst_sel", sel, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_cnt", flit_cnt, 0);
    chk("e_rst_pop0", ipop_0, 0);
    rst_ = 1;
    #1;
    chk("e_idle_pop0", ipop_0, 0);
    tick;
    chk("e_no_grant_busy", busy, 0);
    chk("e_no_grant_sel", sel, 0);
    chk("e_err", err, 1);
    // DATA while idle, then a legal packet
    do_reset;
    chk("f_err_clr", err, 0);
    drv(1, FT_DATA, 0, FT_NONE, 1);
    chk("f_pop0", ipop_0, 0);
    tick;
    chk("f_err", err, 1);
    chk("f_busy", busy, 0);
    drv(1, FT_HEAD, 0, FT_NONE, 1);
    tick;
    chk("f_sel", sel, 5'b00001);
    drv(1, FT_HEAD, 0, FT_NONE, 1);
    tick;
    drv(1, FT_TAIL, 0, FT_NONE, 1);
    tick;
    chk("f_cnt", flit_cnt, 2);
    chk("f_busy_end", busy, 0);
    chk("f_err_sticky", err, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_arb.md
Name: mux_arb

Overview:
- Packet-level round-robin arbiter and sequencer for the 2:1 router output mux (idata_0/idata_1 -> odata).
- Watches flit type and valid on both mux inputs, grants one input per packet, and drives the mux's one-hot sel.
- Holds the grant from HEAD to TAIL and pops flits from the owning input buffer when downstream is ready.
- Counts flits per packet and flags protocol errors, for the characterization and energy benches.

Parameters:
- DATAW, 66: flit width; bits [DATAW-1:DATAW-2] carry the flit type.
- SELW, 5: width of sel, matching the mux's `PORT_P1; one-hot, bit i selects input i.
- CNTW, 8: width of the flit counter.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- ivalid_0  in  1  input 0 has a flit at the head of its buffer.
- itype_0  in  2  type field of input 0's head flit.
- ivalid_1  in  1  input 1 has a flit at the head of its buffer.
- itype_1  in  2  type field of input 1's head flit.
- ordy  in  1  downstream can accept a flit this cycle.
- sel  out  SELW  one-hot mux select; 0 means no input is routed.
- ipop_0  out  1  input 0's flit is transferred this cycle; its buffer advances.
- ipop_1  out  1  input 1's flit is transferred this cycle; its buffer advances.
- busy  out  1  a packet is in progress (state LOCKED).
- flit_cnt  out  CNTW  flits transferred in the current or last packet, HEAD and TAIL included.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Type encoding (shared define file): NONE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- Reset (rst_ low, asynchronous): state=IDLE, sel=0, ptr=0, ipop_0=ipop_1=0, busy=0, flit_cnt=0, err=0.
- Reset asserted mid-packet abandons the packet. The next grant needs a fresh HEAD.
- State IDLE:
  - Request i = ivalid_i AND itype_i==HEAD.
  - If both request, grant input ptr; otherwise grant the single requester.
  - On a grant, at the next edge: state=LOCKED, owner=i, sel=one-hot(i) (bit i set, all others 0), flit_cnt=0.
  - No ipop is issued in IDLE, so the HEAD is popped while LOCKED. Request-to-first-pop latency is 1 cycle.
- State LOCKED:
  - ipop_owner = ivalid_owner AND ordy. This is combinational from registered state and the inputs.
  - ipop of the non-owner is 0.
  - Each pop increments flit_cnt, saturating at all-ones.
  - Popping a flit with itype==TAIL: next edge state=IDLE, sel=0, ptr=~owner (the other input gets priority).
  - flit_cnt holds its final value until the next grant.
- Stalls: ordy=0 or ivalid_owner=0 leaves the lock, sel and the counter unchanged. There is no timeout.
- Protocol errors, each setting err (cleared only by reset):
  - Owner presents HEAD after its first popped flit: pop it, stay LOCKED.
  - Owner presents NONE with valid: pop it, stay LOCKED.
  - In IDLE, an input presents valid with a non-HEAD type: no grant to that input; set err.
  - If the other input requests with HEAD in the same cycle, it is still granted.
- Back-to-back packets:
  - The cycle after a TAIL pop is always IDLE, giving one bubble cycle between packets.
  - The other input wins if it is requesting. Otherwise the same input can be re-granted in that IDLE cycle.
- busy = (state==LOCKED).

Decomposition:
- The type codes, SELW/PORT width and DATAW belong in the existing shared define file, not local to this block.
- Sub-module rr_pick: 2-requester round-robin pick.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; instantiated once.
- The FSM, counter and error logic stay in mux_arb.

Test Plan:
- Single packet on input 1 (HEAD, 20 DATA, TAIL; ordy=1):
  - sel=5'b00010 one cycle after the HEAD is valid.
  - ipop_1 high for 22 consecutive cycles; flit_cnt=22.
  - sel=0 and busy=0 the cycle after the TAIL.
- Both inputs present HEAD in the same cycle after reset (ptr=0):
  - Input 0 is granted first; sel=5'b00001.
  - After input 0's TAIL, 1 IDLE cycle, then sel=5'b00010 and input 1's packet flows.
- Input 1 packet in progress, input 0 presents HEAD mid-packet:
  - ipop_0 stays 0 and sel stays 5'b00010 until input 1's TAIL.
- ordy toggles 1,0,1,0 during a 5-flit packet:
  - Pops occur only in ordy=1 cycles; flit_cnt=5 at the TAIL; no flit is dropped or duplicated.
- rst_ pulsed low mid-packet (after 3 flits):
  - Immediately sel=0, busy=0, flit_cnt=0.
  - Afterwards, DATA flits on the same input produce no grant and set err=1.
- Input 0 presents DATA while IDLE:
  - No grant; err=1 and stays 1 through a following legal packet.
